// File: rtl/gray_conv_sched.sv
// rtl/gray_conv_sched.sv - two-requester round-robin Gray-to-binary converter, one bit per cycle
module gray_conv_sched #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic [W-1:0] gray0,
  output logic         ack0,
  input  logic         req1,
  input  logic [W-1:0] gray1,
  output logic         ack1,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_bin,
  output logic [W-1:0] out_gray,
  output logic         out_id,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] gray_q, gray_d;
  logic [W-1:0] bin_q, bin_d;
  logic [W-1:0] sel_q, sel_d;
  logic         id_q, id_d;
  logic         last_q, last_d;
  logic         ack0_q, ack0_d;
  logic         ack1_q, ack1_d;
  logic         grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gray_q  <= '0;
      bin_q   <= '0;
      sel_q   <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gray_q  <= gray_d;
      bin_q   <= bin_d;
      sel_q   <= sel_d;
      id_q    <= id_d;
      last_q  <= last_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gray_d  = gray_q;
    bin_d   = bin_q;
    sel_d   = sel_q;
    id_d    = id_q;
    last_d  = last_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant   = (req0 && req1) ? ~last_q : req1;
          gray_d  = grant ? gray1 : gray0;
          id_d    = grant;
          last_d  = grant;
          bin_d   = '0;
          sel_d   = {1'b1, {(W-1){1'b0}}};
          ack0_d  = ~grant;
          ack1_d  = grant;
          state_d = CONV;
        end
      end
      CONV: begin
        // sel_q walks MSB->LSB; bin_q>>1 supplies the already-resolved bit above
        bin_d = bin_q | (sel_q & (gray_q ^ (bin_q >> 1)));
        sel_d = sel_q >> 1;
        if (sel_q[0]) state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign out_bin   = bin_q;
  assign out_gray  = gray_q;
  assign out_id    = id_q;

endmodule

// File: tb/tb_gray_conv_sched.sv
// tb/tb_gray_conv_sched.sv - directed self-checking bench for gray_conv_sched (W=4)
module tb_gray_conv_sched;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0 = 1'b0;
  logic [W-1:0] gray0 = '0;
  logic         ack0;
  logic         req1 = 1'b0;
  logic [W-1:0] gray1 = '0;
  logic         ack1;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_bin;
  logic [W-1:0] out_gray;
  logic         out_id;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_cyc;

  logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  gray_conv_sched #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .gray0     (gray0),
    .ack0      (ack0),
    .req1      (req1),
    .gray1     (gray1),
    .ack1      (ack1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .out_gray  (out_gray),
    .out_id    (out_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_any_ack(input int limit);
    int t;
    t = 0;
    do begin
      step();
      t++;
    end while (!(ack0 || ack1) && t < limit);
    chk("ack_timeout", {31'd0, ack0 | ack1}, 32'd1);
    chk("ack_exclusive", {31'd0, ack0 & ack1}, 32'd0);
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ack", {30'd0, ack1, ack0}, 0);
    chk("rst_bin", {28'd0, out_bin}, 0);
    chk("rst_gray", {28'd0, out_gray}, 0);
    chk("rst_id", {31'd0, out_id}, 0);
    step();
    rst_n = 1'b1;
    step();

    // single request, gray 1011 -> bin 1101
    req0 = 1'b1;
    gray0 = 4'b1011;
    step();
    chk("single_ack0", {31'd0, ack0}, 1);
    chk("single_ack1", {31'd0, ack1}, 0);
    chk("single_busy", {31'd0, busy}, 1);
    req0 = 1'b0;
    step();
    chk("single_ack0_pulse", {31'd0, ack0}, 0);
    step();
    step();
    chk("single_early_valid", {31'd0, out_valid}, 0);
    step();
    chk("single_valid", {31'd0, out_valid}, 1);
    chk("single_bin", {28'd0, out_bin}, 32'b1101);
    chk("single_gray", {28'd0, out_gray}, 32'b1011);
    chk("single_id", {31'd0, out_id}, 0);
    out_ready = 1'b1;
    step();
    chk("single_accept_valid", {31'd0, out_valid}, 0);
    chk("single_accept_busy", {31'd0, busy}, 0);

    // sweep all codes through requester 1, back-to-back
    req1 = 1'b1;
    gray1 = gtab[0];
    last_cyc = 0;
    for (int k = 0; k < 16; k++) begin
      wait_any_ack(12);
      chk("sweep_ack1", {31'd0, ack1}, 1);
      if (k > 0) chk("sweep_period", cyc - last_cyc, 6);
      last_cyc = cyc;
      if (k < 15) gray1 = gtab[k+1];
      else req1 = 1'b0;
      repeat (4) step();
      chk("sweep_valid", {31'd0, out_valid}, 1);
      chk("sweep_bin", {28'd0, out_bin}, k);
      chk("sweep_gray", {28'd0, out_gray}, {28'd0, gtab[k]});
      chk("sweep_id", {31'd0, out_id}, 1);
    end
    step();
    chk("sweep_end_idle", {31'd0, busy}, 0);
    out_ready = 1'b0;

    // arbitration after reset: 0,1,0,1
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req0 = 1'b1;
    req1 = 1'b1;
    gray0 = 4'h3;
    gray1 = 4'h5;
    out_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      wait_any_ack(12);
      chk("arb_ack0", {31'd0, ack0}, (g % 2 == 0) ? 1 : 0);
      chk("arb_ack1", {31'd0, ack1}, (g % 2 == 1) ? 1 : 0);
      if (g == 3) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    repeat (6) step();
    chk("arb_end_idle", {31'd0, busy}, 0);

    // backpressure with requester 1 pending
    out_ready = 1'b0;
    req0 = 1'b1;
    gray0 = 4'b0110;
    wait_any_ack(4);
    chk("bp_ack0", {31'd0, ack0}, 1);
    req0 = 1'b0;
    req1 = 1'b1;
    gray1 = 4'b0011;
    repeat (4) step();
    chk("bp_valid", {31'd0, out_valid}, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_valid", {31'd0, out_valid}, 1);
      chk("bp_hold_bin", {28'd0, out_bin}, 32'b0100);
      chk("bp_hold_gray", {28'd0, out_gray}, 32'b0110);
      chk("bp_hold_id", {31'd0, out_id}, 0);
      chk("bp_no_ack1", {31'd0, ack1}, 0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_accept_valid", {31'd0, out_valid}, 0);
    chk("bp_accept_idle", {31'd0, busy}, 0);
    chk("bp_accept_no_ack1", {31'd0, ack1}, 0);
    step();
    chk("bp_ack1_after_idle", {31'd0, ack1}, 1);
    req1 = 1'b0;
    repeat (4) step();
    chk("bp2_valid", {31'd0, out_valid}, 1);
    chk("bp2_bin", {28'd0, out_bin}, 32'b0010);
    chk("bp2_id", {31'd0, out_id}, 1);
    step();
    out_ready = 1'b0;

    // reset in the second CONV cycle
    req0 = 1'b1;
    gray0 = 4'b1111;
    wait_any_ack(4);
    chk("mr_ack0", {31'd0, ack0}, 1);
    req0 = 1'b0;
    step();
    chk("mr_partial_bin", {28'd0, out_bin}, 32'b1000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_bin", {28'd0, out_bin}, 0);
    chk("mr_gray", {28'd0, out_gray}, 0);
    chk("mr_busy", {31'd0, busy}, 0);
    chk("mr_valid", {31'd0, out_valid}, 0);
    chk("mr_ack", {30'd0, ack1, ack0}, 0);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mr_no_valid", {31'd0, out_valid}, 0);
      chk("mr_no_ack", {30'd0, ack1, ack0}, 0);
    end

    // first tie after reset goes to requester 0
    req0 = 1'b1;
    req1 = 1'b1;
    wait_any_ack(4);
    chk("tie_ack0", {31'd0, ack0}, 1);
    req0 = 1'b0;
    req1 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_conv_sched.md
GRAY_CONV_SCHED -- requirements
Module: gray_conv_sched

Interface
REQ-001 Parameter: W, default 4, data width of Gray and binary words (W >= 2).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0  input  1  requester 0 conversion request.
REQ-005 gray0  input  W  requester 0 Gray-code operand.
REQ-006 ack0  output  1  one-cycle pulse; requester 0 operand captured.
REQ-007 req1  input  1  requester 1 conversion request.
REQ-008 gray1  input  W  requester 1 Gray-code operand.
REQ-009 ack1  output  1  one-cycle pulse; requester 1 operand captured.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_bin  output  W  converted binary result.
REQ-013 out_gray  output  W  captured Gray operand echoed with the result.
REQ-014 out_id  output  1  requester that owns the result (0 or 1).
REQ-015 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-016 FSM states SHALL be IDLE, CONV, and HOLD; encoding is free.
REQ-017 IDLE: at a rising edge with req0|req1 high, the FSM SHALL capture the granted operand, load out_id, clear out_bin, and go to CONV; otherwise it SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin:
  - single request: that requester is granted;
  - both requests: the requester not served last is granted;
  - the last-served pointer updates at capture.
REQ-019 ackN SHALL be high for exactly the one cycle following the capture edge; it SHALL never be high for both requesters or outside that cycle.
REQ-020 Requesters SHALL hold reqN and grayN stable until ackN; a reqN high while the FSM is in IDLE is a new request; reqN dropped before grant is ignored.
REQ-021 CONV SHALL resolve one bit per cycle, MSB first, over exactly W edges:
  - edge 1: B[W-1] = G[W-1];
  - edge k: B[W-k] = B[W-k+1] ^ G[W-k].
REQ-022 At the W-th CONV edge the FSM SHALL enter HOLD and assert out_valid; the result is available W cycles after the capture edge.
REQ-023 HOLD: out_valid, out_bin, out_gray, and out_id SHALL remain stable until an edge with out_ready high. At that edge the FSM SHALL deassert out_valid and return to IDLE.
REQ-024 out_ready already high when out_valid rises SHALL complete the transfer at the next edge; the sustained period is W+2 cycles per conversion.
REQ-025 Requests arriving during CONV or HOLD SHALL be left pending, not acked, and arbitrated on return to IDLE.
REQ-026 out_ready outside HOLD SHALL have no effect.

Reset
REQ-027 rst_n low SHALL immediately force the following, independent of clk:
  - state IDLE;
  - ack0, ack1, out_valid, and busy low;
  - out_bin, out_gray, and out_id set to 0;
  - last-served pointer set to requester 1, so requester 0 wins the first tie.
REQ-028 Reset during CONV or HOLD SHALL abort the operation; no ack, out_valid, or stale result SHALL appear after reset release until a new capture.

Verification (W=4)
REQ-029 Single request: req0 with gray0=1011 -> ack0 pulses 1 cycle; 4 cycles after capture, out_valid=1 with out_bin=1101, out_gray=1011, out_id=0.
REQ-030 Sweep: all 16 codes 0000..1000 via req1 with out_ready=1 -> out_bin equals the binary value (0000->0000, 0100->0111, 1000->1111); one result every 6 cycles.
REQ-031 Arbitration after reset: req0 and req1 held high continuously -> grants go 0, 1, 0, 1; the first grant goes to req0.
REQ-032 Backpressure: out_ready low for 5 cycles in HOLD with req1 pending -> outputs are stable and no ack1; when out_ready rises, the result is accepted, then req1 is captured 1 cycle after return to IDLE.
REQ-033 Mid-operation reset: rst_n low on the 2nd CONV cycle -> outputs zero asynchronously and busy=0; after release with no requests, out_valid stays 0.
